fifo_burst_rd: RTL and testbench

FIFO_BURST_RD -- requirements
Module: fifo_burst_rd

---
 rtl/fifo_burst_rd.sv | 199 +++++++++++++++++++
 tb/tb_fifo_burst_rd.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_rd.sv
// fifo_burst_rd
//
// Reads a burst of words from a FIFO read port and forwards them to a
// valid/ready stream. A request names how many words to read. The block
// pops that many words, marks the final one with last_o, and pulses done_o
// for one cycle once that final word has been accepted downstream.
//
// A two-entry output buffer sits between the FIFO pop and the stream. The
// pop decision uses only the current buffer occupancy, so the FIFO read
// strobe never depends combinationally on downstream ready.
//
// Parameters
//   DATA_W        data word width (matches the FIFO data width)
//   LEN_W         width of the burst length field, max burst 2**LEN_W-1
//
// Ports
//   clk           single clock, rising edge
//   nreset        synchronous active-low reset
//   req_i         burst request, only looked at while idle
//   req_len_i     burst length in words, captured with req_i
//   fifo_rd_o     FIFO pop strobe, one word per asserted cycle
//   fifo_data_i   FIFO head word, valid while fifo_empty_i is low
//   fifo_empty_i  FIFO empty flag
//   valid_o       stream valid
//   data_o        stream data
//   last_o        final word of the burst, qualified by valid_o
//   ready_i       stream ready
//   busy_o        high whenever a burst is in progress
//   done_o        one-cycle burst-complete pulse
//   abort_i       (only with FIFO_BURST_RD_ABORT_EN) cancels the running
//                 burst, flushes buffered words and finishes via done_o
//
// Optional feature: define FIFO_BURST_RD_ABORT_EN to add abort_i.

module fifo_burst_rd #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              fifo_rd_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef FIFO_BURST_RD_ABORT_EN
    ,
    input  logic              abort_i
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  remaining;

    // Buffer entry 0 (head) drives the stream outputs; entry 1 is the tail.
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic [DATA_W-1:0] tail_data;
    logic              tail_last;
    logic [1:0]        occupancy;

    logic              push;
    logic              pop;
    logic              push_last;
`ifdef FIFO_BURST_RD_ABORT_EN
    logic              flush;
`endif

    // Next-state logic and the buffer push/pop decisions. A pop from the
    // FIFO (push into the buffer) is gated on occupancy < 2 rather than on
    // ready_i. This keeps the FIFO strobe free of any ready path. Throughput
    // still holds at one word per cycle because occupancy sits at 1 in
    // steady state.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = (occupancy != 2'd0) && ready_i;
        push_last  = (remaining == LEN_W'(1));
`ifdef FIFO_BURST_RD_ABORT_EN
        flush      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_next = (req_len_i != '0) ? READ : DONE;
                end
            end
            READ: begin
                push = (remaining != '0) && !fifo_empty_i && (occupancy < 2'd2);
                if (push && push_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef FIFO_BURST_RD_ABORT_EN
        // Abort overrides any pop in the same cycle and goes straight to DONE.
        if (abort_i && ((state == READ) || (state == DRAIN))) begin
            push       = 1'b0;
            flush      = 1'b1;
            state_next = DONE;
        end
`endif
    end

    // State register, remaining-word counter and the two-entry output
    // buffer. Words always leave from the head. A simultaneous push and pop
    // keeps occupancy constant. Occupancy never reaches 2 while pushing, so
    // no overflow case exists.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= IDLE;
            remaining <= '0;
            occupancy <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            state <= state_next;
`ifdef FIFO_BURST_RD_ABORT_EN
            if (flush) begin
                remaining <= '0;
                occupancy <= 2'd0;
            end else
`endif
            begin
                if ((state == IDLE) && req_i) begin
                    remaining <= req_len_i;
                end else if (push) begin
                    remaining <= remaining - LEN_W'(1);
                end

                case ({push, pop})
                    2'b10: begin
                        if (occupancy == 2'd0) begin
                            head_data <= fifo_data_i;
                            head_last <= push_last;
                        end else begin
                            tail_data <= fifo_data_i;
                            tail_last <= push_last;
                        end
                        occupancy <= occupancy + 2'd1;
                    end
                    2'b01: begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        occupancy <= occupancy - 2'd1;
                    end
                    2'b11: begin
                        if (occupancy == 2'd1) begin
                            head_data <= fifo_data_i;
                            head_last <= push_last;
                        end else begin
                            head_data <= tail_data;
                            head_last <= tail_last;
                            tail_data <= fifo_data_i;
                            tail_last <= push_last;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign fifo_rd_o = push;
    assign valid_o   = (occupancy != 2'd0);
    assign data_o    = head_data;
    assign last_o    = head_last;
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);

endmodule

// File: tb/tb_fifo_burst_rd.sv
// tb_fifo_burst_rd
//
// Bench for fifo_burst_rd. The FIFO is a queue owned by the bench. The
// reference model describes a burst as "the next N words leaving the FIFO,
// in order, with the N-th one flagged last". It expects done_o in the cycle
// after the last word is accepted, and busy_o from the cycle after the
// request through the done cycle. Directed scenarios come first, then
// randomized bursts with random ready, random FIFO refill and random
// requests driven while a burst is already running.

module tb_fifo_burst_rd;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    logic              clk;
    logic              nreset;
    logic              req_i;
    logic [LEN_W-1:0]  req_len_i;
    logic              fifo_rd_o;
    logic [DATA_W-1:0] fifo_data_i;
    logic              fifo_empty_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              last_o;
    logic              ready_i;
    logic              busy_o;
    logic              done_o;
`ifdef FIFO_BURST_RD_ABORT_EN
    logic              abort_i;
`endif

    fifo_burst_rd #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .req_i        (req_i),
        .req_len_i    (req_len_i),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef FIFO_BURST_RD_ABORT_EN
        ,
        .abort_i      (abort_i)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] fifo_q[$];
    word_t             exp_q[$];

    int   num_checks;
    int   num_fails;
    int   cyc;
    int   cur_len;
    int   pops;
    int   stall_pops;
    int   first_pop;
    int   last_pop;
    int   first_xfer;
    int   last_xfer;
    logic in_burst;
    logic done_exp;
    logic aborted;
    logic valid_zero_exp;
    logic prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic clearModel();
        exp_q.delete();
        in_burst       = 1'b0;
        done_exp       = 1'b0;
        aborted        = 1'b0;
        valid_zero_exp = 1'b0;
        prev_stall     = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        nreset       = 1'b0;
        req_i        = 1'b0;
        ready_i      = 1'b1;
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = fifo_empty_i ? DATA_W'($urandom) : fifo_q[0];
`ifdef FIFO_BURST_RD_ABORT_EN
        abort_i      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_last", last_o, 0);
        checkOutput("rst_data", data_o, 0);
        checkOutput("rst_rd", fifo_rd_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        clearModel();
    endtask

    // One clock cycle: drive inputs at the falling edge, sample just after,
    // compare against the model, then advance the model for the next edge.
    task automatic runCycle(input logic rdy, input logic rq, input logic [LEN_W-1:0] ln,
                            input logic push, input logic [DATA_W-1:0] pdata,
                            input logic ab);
        word_t e;
        logic  done_next;
        logic  accept;
        @(negedge clk);
        nreset = 1'b1;
        if (push) fifo_q.push_back(pdata);
        ready_i      = rdy;
        req_i        = rq;
        req_len_i    = ln;
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = fifo_empty_i ? DATA_W'($urandom) : fifo_q[0];
`ifdef FIFO_BURST_RD_ABORT_EN
        abort_i      = ab;
`endif
        #2;
        cyc++;
        done_next = 1'b0;
        checkOutput("done", done_o, done_exp);
        checkOutput("busy", busy_o, in_burst);
        if (!in_burst) begin
            checkOutput("idle_rd", fifo_rd_o, 0);
            checkOutput("idle_valid", valid_o, 0);
        end
        if (valid_zero_exp) checkOutput("abort_valid", valid_o, 0);
        if (prev_stall) begin
            checkOutput("hold_valid", valid_o, 1);
            checkOutput("hold_data", data_o, prev_data);
            checkOutput("hold_last", last_o, prev_last);
        end
        if (ab) begin
            checkOutput("abort_rd", fifo_rd_o, 0);
            exp_q.delete();
            aborted   = 1'b1;
            done_next = 1'b1;
        end else begin
            // Transfers are checked before this cycle's pop is recorded, so
            // a word cannot match if it reaches data_o in its own pop cycle.
            if (valid_o && rdy) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("data", data_o, e.data);
                    checkOutput("last", last_o, e.last);
                    if (e.last) done_next = 1'b1;
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                end
            end
            if (fifo_rd_o) begin
                checkOutput("pop_when_empty", fifo_empty_i, 0);
                if (fifo_q.size() != 0) begin
                    pops++;
                    if (!rdy) stall_pops++;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    checkOutput("pop_within_len", (pops <= cur_len), 1);
                    e.data = fifo_q.pop_front();
                    e.last = (pops == cur_len);
                    exp_q.push_back(e);
                end
            end
        end
        if (done_exp) begin
            if (!aborted) checkOutput("burst_pops", pops, cur_len);
            checkOutput("burst_leftover", exp_q.size(), 0);
        end
        prev_stall     = valid_o && !rdy && !ab;
        prev_data      = data_o;
        prev_last      = last_o;
        valid_zero_exp = ab;
        accept = rq && !in_burst;
        if (accept) begin
            cur_len    = int'(ln);
            pops       = 0;
            stall_pops = 0;
            aborted    = 1'b0;
            first_pop  = -1;
            last_pop   = -1;
            first_xfer = -1;
            last_xfer  = -1;
            if (ln == '0) done_next = 1'b1;
        end
        if (accept) in_burst = 1'b1;
        else if (done_exp) in_burst = 1'b0;
        done_exp = done_next;
    endtask

    // Issue one burst and run until the model says it is over.
    // mode 0: random ready and refill; 1: ready high, no refill;
    // 2: ready low for 5 cycles then high; 3: FIFO empty for 3 cycles then
    // one word every other cycle; 4: ready high, abort after 3 pops.
    task automatic applyStimulus(input int len, input int mode);
        int   k;
        logic rdy;
        logic pu;
        logic ab;
        logic rq;
        logic [LEN_W-1:0] ln;
        k = 0;
        while (k == 0 || (in_burst && k < 300)) begin
            rdy = 1'b1;
            pu  = 1'b0;
            ab  = 1'b0;
            case (mode)
                0: begin
                    rdy = ($urandom_range(0, 3) != 0);
                    pu  = ($urandom_range(0, 1) == 1) && (fifo_q.size() < 24);
                end
                2: rdy = (k >= 5);
                3: pu = (k >= 3) && (((k - 3) % 2) == 0);
                4: ab = (k > 0) && in_burst && !done_exp && !aborted && (pops == 3);
                default: begin
                end
            endcase
            if (k == 0) begin
                rq = 1'b1;
                ln = LEN_W'(len);
            end else begin
                rq = in_burst && !done_exp && ($urandom_range(0, 1) == 1);
                ln = LEN_W'($urandom);
            end
            runCycle(rdy, rq, ln, pu, DATA_W'($urandom), ab);
            k++;
        end
        if (in_burst) begin
            checkOutput("burst_timeout", 1, 0);
            doReset();
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            runCycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        clk          = 1'b0;
        nreset       = 1'b0;
        req_i        = 1'b0;
        req_len_i    = '0;
        ready_i      = 1'b0;
        fifo_data_i  = '0;
        fifo_empty_i = 1'b1;
`ifdef FIFO_BURST_RD_ABORT_EN
        abort_i      = 1'b0;
`endif
        num_checks = 0;
        num_fails  = 0;
        cyc        = 0;
        cur_len    = 0;
        pops       = 0;
        stall_pops = 0;
        prev_data  = '0;
        prev_last  = 1'b0;
        clearModel();

        // Reset with a non-empty FIFO, then idle: nothing may be popped.
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        doReset();
        idleCycles(4);
        checkOutput("idle_fifo_kept", fifo_q.size(), 3);

        // Full-rate burst of four preloaded words.
        fifo_q.delete();
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        fifo_q.push_back(8'hA3);
        fifo_q.push_back(8'hA4);
        applyStimulus(4, 1);
        checkOutput("rate_pop_span", last_pop - first_pop, 3);
        checkOutput("rate_xfer_span", last_xfer - first_xfer, 3);
        checkOutput("rate_fifo_drained", fifo_q.size(), 0);
        idleCycles(2);

        // Backpressure: only two words fit in the buffer while stalled.
        fifo_q.delete();
        for (int i = 0; i < 3; i++) fifo_q.push_back(DATA_W'($urandom));
        applyStimulus(3, 2);
        checkOutput("stall_pops", stall_pops, 2);
        idleCycles(2);

        // Starved FIFO.
        fifo_q.delete();
        applyStimulus(2, 3);
        checkOutput("starve_pops", pops, 2);
        idleCycles(2);

        // Zero-length request: done pulse, nothing popped.
        fifo_q.delete();
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'hA5);
        applyStimulus(0, 1);
        checkOutput("zero_len_fifo_kept", fifo_q.size(), 2);
        idleCycles(3);

        // Reset in the middle of a burst: buffered words vanish, no done.
        for (int i = 0; i < 6; i++) fifo_q.push_back(DATA_W'($urandom));
        runCycle(1'b0, 1'b1, LEN_W'(6), 1'b0, '0, 1'b0);
        runCycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        runCycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        doReset();
        idleCycles(3);

`ifdef FIFO_BURST_RD_ABORT_EN
        // Abort after three pops leaves the rest in the FIFO.
        fifo_q.delete();
        for (int i = 0; i < 8; i++) fifo_q.push_back(DATA_W'(8'hC0 + i));
        applyStimulus(8, 4);
        checkOutput("abort_fifo_left", fifo_q.size(), 5);
        idleCycles(2);
`endif

        // Randomized bursts.
        fifo_q.delete();
        for (int b = 0; b < 40; b++) begin
            applyStimulus($urandom_range(0, 15), 0);
            for (int i = 0; i < $urandom_range(0, 2); i++) begin
                runCycle(1'b1, 1'b0, '0,
                         ($urandom_range(0, 1) == 1) && (fifo_q.size() < 24),
                         DATA_W'($urandom), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fails);
        $finish;
    end

endmodule
